// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage and its neighbours in the pipeline:
// opcode constants, request FSM state encoding, write-back payload and decode helpers.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 7'h00;
  localparam logic [OP_W-1:0] OP_SUB = 7'h01;
  localparam logic [OP_W-1:0] OP_MUL = 7'h02;
  localparam logic [OP_W-1:0] OP_LDW = 7'h10;
  localparam logic [OP_W-1:0] OP_STW = 7'h11;
  localparam logic [OP_W-1:0] OP_NOP = 7'h3F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wb_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LDW) || (op == OP_STW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
//   req/we/addr/wdata : request, held stable until gnt
//   gnt               : request accepted this cycle
//   rvalid/rdata      : load data return
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 32
) ();
  import mem_stage_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_req_fsm.sv
// Data-memory request sequencer: IDLE/REQ/WAIT with a timeout counter.
//   mem_op      : LDW/STW presented this cycle (only accepted in IDLE)
//   is_store    : 1 = STW
//   addr_in/wdata_in/dst_in : access operands, latched on acceptance
//   dmem        : data-memory bus master
//   stall       : combinational, busy or accepting an access this cycle
//   ld_done_c   : combinational, load data returns this cycle; ld_wb_c holds dst/data
//   mem_err     : sticky timeout flag
module mem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REQ_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_op,
  input  logic               is_store,
  input  logic [DATA_W-1:0]  addr_in,
  input  logic [DATA_W-1:0]  wdata_in,
  input  logic [REG_W-1:0]   dst_in,
  mem_stage_if.master        dmem,
  output logic               stall,
  output logic               ld_done_c,
  output wb_t                ld_wb_c,
  output logic               mem_err
);

  mem_state_t        state_q, state_d;
  logic              start, done_st, timeout;
  logic              we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [REG_W-1:0]  dst_q;
  logic [CNT_W-1:0]  cnt_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state; completion wins over timeout on the last allowed cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (done_st || ld_done_c || timeout) state_d = S_IDLE;
        else if (dmem.gnt)                   state_d = S_WAIT;
      end
      S_WAIT: if (ld_done_c || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and completion events decoded from the current state
  always_comb begin
    start     = 1'b0;
    stall     = 1'b0;
    done_st   = 1'b0;
    ld_done_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        start = mem_op;
        stall = mem_op;
      end
      S_REQ: begin
        stall     = 1'b1;
        done_st   = dmem.gnt & we_q;
        ld_done_c = dmem.gnt & dmem.rvalid & ~we_q;
      end
      S_WAIT: begin
        stall     = 1'b1;
        ld_done_c = dmem.rvalid;
      end
      default: ;
    endcase
    timeout = (state_q != S_IDLE) && !done_st && !ld_done_c &&
              (cnt_q == CNT_W'(REQ_TIMEOUT - 1));
  end

  // Access operands, timeout counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (start) begin
        we_q    <= is_store;
        addr_q  <= ADDR_W'({addr_in[DATA_W-1:2], 2'b00});
        wdata_q <= wdata_in;
        dst_q   <= dst_in;
      end
      if (state_d == S_IDLE)      cnt_q <= '0;
      else if (state_q != S_IDLE) cnt_q <= cnt_q + CNT_W'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign dmem.req   = (state_q == S_REQ);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign ld_wb_c    = '{dst: dst_q, data: dmem.rdata};
  assign mem_err    = err_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline stage 4: passes ALU results, performs LDW/STW on the data memory and
// drives write-back plus the mem-stage bypass pair.
//   ex_*        : Execution stage output
//   dmem        : data-memory bus master
//   wb_*        : write-back entry (one-cycle pulse per instruction)
//   bp_*_mem    : bypass tag/value, zero when no write-back
//   stall       : hold stages 1-3 while an access is outstanding
//   mem_err     : sticky memory timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REQ_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [OP_W-1:0]    ex_opcode,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [DATA_W-1:0]  ex_store,
  input  logic [REG_W-1:0]   ex_dst,
  mem_stage_if.master        dmem,
  output logic               wb_valid,
  output logic [REG_W-1:0]   wb_dst,
  output logic [DATA_W-1:0]  wb_data,
  output logic [REG_W-1:0]   bp_reg_mem,
  output logic [DATA_W-1:0]  bp_data_mem,
  output logic               stall,
  output logic               mem_err
);

  logic mem_op_c, alu_wb_c, ld_done_c;
  wb_t  ld_wb_c, wb_q;
  logic wb_valid_q;

  assign mem_op_c = ex_valid & is_mem_op(ex_opcode);
  // Writes to r0 are dropped; ex_* is ignored while the stage is stalled
  assign alu_wb_c = ex_valid & is_alu_op(ex_opcode) & (ex_dst != '0) & ~stall;

  mem_req_fsm #(
    .ADDR_W      (ADDR_W),
    .REQ_TIMEOUT (REQ_TIMEOUT)
  ) u_req_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_op    (mem_op_c),
    .is_store  (ex_opcode == OP_STW),
    .addr_in   (ex_result),
    .wdata_in  (ex_store),
    .dst_in    (ex_dst),
    .dmem      (dmem),
    .stall     (stall),
    .ld_done_c (ld_done_c),
    .ld_wb_c   (ld_wb_c),
    .mem_err   (mem_err)
  );

  // Write-back register; payload zeroed when idle so the bypass pair reads 0/0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
    end else begin
      wb_valid_q <= alu_wb_c | ld_done_c;
      if (ld_done_c)     wb_q <= ld_wb_c;
      else if (alu_wb_c) wb_q <= '{dst: ex_dst, data: ex_result};
      else               wb_q <= '0;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_dst      = wb_q.dst;
  assign wb_data     = wb_q.data;
  assign bp_reg_mem  = wb_q.dst;
  assign bp_data_mem = wb_q.data;

endmodule
